uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
Shares one UART transmitter between NREQ requesters. Each requester presents a fixed-length message of NBYTES bytes. The block arbitrates round-robin, latches the winning message, and feeds it byte by byte to the transmitter's data/data-ready/available handshake. It sits between the processing blocks (ALU result path, status reporters) and the UART TX.

Parameters:
NREQ, 2, number of requesters (>=2)
DATA_BITS, 8, byte width; must match the transmitter
NBYTES, 2, bytes per message (>=1)
BUSY_TIMEOUT, 4, cycles to wait for the transmitter to drop available after a data-ready pulse before retrying

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_req  in  NREQ  per-requester message-pending level
i_msg  in  NREQ*NBYTES*DATA_BITS  requester k slice = [(k+1)*NBYTES*DATA_BITS-1 : k*NBYTES*DATA_BITS]; byte 0 = slice LSbits
o_grant  out  NREQ  one-hot, one-cycle pulse: message of that requester latched
o_done  out  NREQ  one-hot, one-cycle pulse: last byte's stop period finished
o_busy  out  1  high whenever state != IDLE
i_tx_available  in  1  transmitter idle flag
o_tx_data  out  DATA_BITS  byte to transmitter
o_tx_data_ready  out  1  one-cycle load strobe to transmitter

Behaviour:
- One clock, reset synchronous active-high. All outputs and state are registered.
- Reset values: state IDLE, o_grant=0, o_done=0, o_busy=0, o_tx_data=0, o_tx_data_ready=0, byte_cnt=0, rr pointer=0 (requester 0 has highest priority). Reset mid-message aborts silently: no o_done pulse, latched message discarded.
- States (one-hot): IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE.
- IDLE: on an edge with |i_req:
  - Latch the winner's slice into the shift buffer; byte_cnt=0.
  - o_grant<=onehot(winner) for exactly 1 cycle; go to ISSUE.
  - i_req is not sampled again until the next IDLE.
- Round-robin: search starts at the rr pointer and goes upward with wrap. On o_done the pointer becomes owner+1 mod NREQ.
- ISSUE: wait for i_tx_available=1, then:
  - o_tx_data<=buffer byte 0; o_tx_data_ready<=1 for exactly 1 cycle.
  - Clear the timeout counter; go to WAIT_BUSY.
  - o_tx_data holds until the next issue.
- WAIT_BUSY: wait for i_tx_available=0, then go to WAIT_IDLE.
  - The transmitter drops available 1 cycle after sampling data-ready, so at least 2 cycles are spent here.
  - If BUSY_TIMEOUT cycles pass with available still 1, go back to ISSUE and re-issue the same byte.
- WAIT_IDLE: wait for i_tx_available=1, then:
  - If byte_cnt==NBYTES-1: o_done<=onehot(owner) for 1 cycle, update the pointer, go to IDLE.
  - Otherwise: shift the buffer right by DATA_BITS, byte_cnt+1, go to ISSUE.
- Invariant: o_tx_data_ready is never asserted while i_tx_available=0, because the transmitter reloads on data-ready in any state.
- Minimum gap: after o_done, the next o_grant comes no earlier than 1 cycle later (IDLE is always visited).
- Bytes go out LSByte first. byte_cnt width is $clog2(NBYTES)+1. The timeout counter saturates.
- Requests raised while busy stay pending and are arbitrated at the next IDLE.
- A requester dropping i_req after its grant does not affect the latched message.

Decomposition:
- Package (shared localparams): state one-hot encodings, and a helper for the slice index of requester k.
- One sub-module: rr_arbiter (i_req, pointer -> one-hot grant plus encoded index, purely combinational).
- The scheduler keeps the FSM, buffer, counters and pointer.

Test Plan:
- Reset then idle: no requests, available=1 for 50 cycles -> o_tx_data_ready never high, o_busy=0, all pulses 0.
- Single message: NREQ=2, NBYTES=2, i_req=01, msg0=16'hA55A, real tx_uart plus tick generator -> o_grant=01 once; bytes 5A then A5 observed on the serial line; exactly 2 data-ready pulses; o_done=01 once after the second stop bit.
- Contention: i_req=11 held, msg0=16'h1111, msg1=16'h2222 -> grants in order 01,10,01,10; bytes 11,11,22,22,11,11,...; no requester served twice in a row.
- Timeout: transmitter stub holds available=1 and ignores the first strobe -> strobe repeats after BUSY_TIMEOUT cycles with the same byte; the second strobe is accepted normally.
- Reset mid-message: assert i_reset during byte 1 of requester 1 -> next cycle all outputs are at reset values; no o_done; the next grant follows pointer=0 priority.
- Protocol check (assertion, all tests): o_tx_data_ready implies i_tx_available was 1 in that cycle, and o_tx_data is stable while o_tx_data_ready=1.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_tx_scheduler_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0001,
        ST_ISSUE     = 4'b0010,
        ST_WAIT_BUSY = 4'b0100,
        ST_WAIT_IDLE = 4'b1000
    } state_t;

    // LSB position of requester k's message inside the packed message bus.
    function automatic int unsigned msg_slice_lsb(
        input int unsigned k,
        input int unsigned nbytes,
        input int unsigned data_bits
    );
        return k * nbytes * data_bits;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at i_pointer and wraps upward.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_pointer,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_index,
    output logic            o_valid
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        o_grant = '0;
        o_index = '0;
        o_valid = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            sum = {1'b0, i_pointer} + (PW+1)'(off);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!o_valid && i_req[idx]) begin
                o_valid      = 1'b1;
                o_grant[idx] = 1'b1;
                o_index      = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NREQ fixed-length
// message sources; feeds bytes LSByte first over the data/data-ready/available handshake.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned NBYTES       = 2,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic [NREQ-1:0]                 i_req,
    input  logic [NREQ*NBYTES*DATA_BITS-1:0] i_msg,
    output logic [NREQ-1:0]                 o_grant,
    output logic [NREQ-1:0]                 o_done,
    output logic                            o_busy,
    input  logic                            i_tx_available,
    output logic [DATA_BITS-1:0]            o_tx_data,
    output logic                            o_tx_data_ready
);

    localparam int unsigned MSG_BITS = NBYTES * DATA_BITS;
    localparam int unsigned PW       = $clog2(NREQ);
    localparam int unsigned CW       = $clog2(NBYTES) + 1;
    localparam int unsigned TW       = $clog2(BUSY_TIMEOUT + 1);

    state_t                state_q, state_d;
    logic [MSG_BITS-1:0]   buffer_q, buffer_d;
    logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [PW-1:0]         pointer_q, pointer_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [NREQ-1:0]       grant_d, done_d;
    logic [DATA_BITS-1:0]  tx_data_d;
    logic                  tx_ready_d;

    logic [NREQ-1:0]       arb_grant;
    logic [PW-1:0]         arb_index;
    logic                  arb_valid;
    logic [MSG_BITS-1:0]   winner_msg;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arbiter (
        .i_req     (i_req),
        .i_pointer (pointer_q),
        .o_grant   (arb_grant),
        .o_index   (arb_index),
        .o_valid   (arb_valid)
    );

    always_comb begin
        winner_msg = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (arb_index == PW'(k)) begin
                winner_msg = i_msg[msg_slice_lsb(k, NBYTES, DATA_BITS) +: MSG_BITS];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        buffer_d   = buffer_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        pointer_d  = pointer_q;
        owner_d    = owner_q;
        tx_data_d  = o_tx_data;
        grant_d    = '0;
        done_d     = '0;
        tx_ready_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    buffer_d   = winner_msg;
                    byte_cnt_d = '0;
                    owner_d    = arb_index;
                    grant_d    = arb_grant;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_tx_available) begin
                    tx_data_d  = buffer_q[DATA_BITS-1:0];
                    tx_ready_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // The transmitter may have missed the strobe; re-issue the same byte after the timeout.
                if (!i_tx_available) begin
                    state_d = ST_WAIT_IDLE;
                end else if (tmo_q >= TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = ST_ISSUE;
                end else if (tmo_q != TW'(BUSY_TIMEOUT)) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (i_tx_available) begin
                    if (byte_cnt_q == CW'(NBYTES - 1)) begin
                        done_d    = NREQ'(1) << owner_q;
                        pointer_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        buffer_d   = buffer_q >> DATA_BITS;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q         <= ST_IDLE;
            buffer_q        <= '0;
            byte_cnt_q      <= '0;
            tmo_q           <= '0;
            pointer_q       <= '0;
            owner_q         <= '0;
            o_grant         <= '0;
            o_done          <= '0;
            o_busy          <= 1'b0;
            o_tx_data       <= '0;
            o_tx_data_ready <= 1'b0;
        end else begin
            state_q         <= state_d;
            buffer_q        <= buffer_d;
            byte_cnt_q      <= byte_cnt_d;
            tmo_q           <= tmo_d;
            pointer_q       <= pointer_d;
            owner_q         <= owner_d;
            o_grant         <= grant_d;
            o_done          <= done_d;
            o_busy          <= (state_d != ST_IDLE);
            o_tx_data       <= tx_data_d;
            o_tx_data_ready <= tx_ready_d;
        end
    end

endmodule
